// File: rtl/gray_sequence_checker_4_bit_pkg.sv
// ============================================================================
// Module   : gray_seq_pkg
// Purpose  : Shared constants, FSM state type and Gray-to-binary conversion
//            for the 4-bit Gray sequence checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_seq_pkg;

  localparam int GRAY_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } state_t;

  // MSB passes straight through; each lower bit folds in the bit above it.
  function automatic logic [GRAY_WIDTH-1:0] gray_to_bin(input logic [GRAY_WIDTH-1:0] g);
    logic [GRAY_WIDTH-1:0] b;
    b[GRAY_WIDTH-1] = g[GRAY_WIDTH-1];
    for (int i = GRAY_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_sequence_checker_4_bit_if.sv
// ============================================================================
// Module   : gray_sequence_checker_4_bit_if
// Purpose  : Signal bundle between a Gray count source/consumer and the checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gray_sequence_checker_4_bit_if #(
  parameter int POS_WIDTH     = 16,
  parameter int ERR_CNT_WIDTH = 8
);
  import gray_seq_pkg::*;

  logic                     Enable_In;
  logic [GRAY_WIDTH-1:0]    Gray_In;
  logic [GRAY_WIDTH-1:0]    Binary_Out;
  logic [POS_WIDTH-1:0]     Position_Out;
  logic                     Dir_Out;
  logic                     Step_Valid_Out;
  logic                     Wrap_Out;
  logic                     Error_Out;
  logic [ERR_CNT_WIDTH-1:0] Error_Count_Out;

  modport master (
    output Enable_In, Gray_In,
    input  Binary_Out, Position_Out, Dir_Out, Step_Valid_Out,
           Wrap_Out, Error_Out, Error_Count_Out
  );

  modport slave (
    input  Enable_In, Gray_In,
    output Binary_Out, Position_Out, Dir_Out, Step_Valid_Out,
           Wrap_Out, Error_Out, Error_Count_Out
  );

endinterface

`default_nettype wire

// File: rtl/gray_sequence_checker_4_bit_sync_chain.sv
// ============================================================================
// Module   : gray_sync_chain
// Purpose  : SYNC_STAGES-deep multi-bit synchronizer with synchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_sync_chain #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [WIDTH-1:0] d,
  output logic      [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_stage [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign q = r_stage[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/gray_sequence_checker_4_bit.sv
// ============================================================================
// Module   : gray_sequence_checker_4_bit
// Purpose  : Synchronizes a 4-bit Gray count, classifies each change as a
//            forward/backward step or error, and tracks position and errors.
//            Optional macro GRAY_SEQ_ERROR_COUNT_EN builds the error counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_sequence_checker_4_bit
  import gray_seq_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int POS_WIDTH     = 16,
  parameter int ERR_CNT_WIDTH = 8
) (
  input wire logic Clk_In,
  input wire logic Reset_In,
  gray_sequence_checker_4_bit_if.slave bus
);

  logic [GRAY_WIDTH-1:0] w_sync_gray;
  logic [GRAY_WIDTH-1:0] w_b_new;
  logic [GRAY_WIDTH-1:0] w_delta;

  state_t                r_state, w_state_nxt;
  logic [GRAY_WIDTH-1:0] r_bin,   w_bin_nxt;
  logic [POS_WIDTH-1:0]  r_pos,   w_pos_nxt;
  logic                  r_dir,   w_dir_nxt;
  logic                  r_step,  w_step_nxt;
  logic                  r_wrap,  w_wrap_nxt;
  logic                  r_err,   w_err_nxt;

  gray_sync_chain #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (GRAY_WIDTH)
  ) u_sync (
    .clk (Clk_In),
    .rst (Reset_In),
    .d   (bus.Gray_In),
    .q   (w_sync_gray)
  );

  assign w_b_new = gray_to_bin(w_sync_gray);
  assign w_delta = w_b_new - r_bin;

  // r_bin doubles as the step reference: both always take the same new sample.
  always_comb begin
    w_state_nxt = r_state;
    w_bin_nxt   = r_bin;
    w_pos_nxt   = r_pos;
    w_dir_nxt   = r_dir;
    w_step_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.Enable_In) begin
          w_state_nxt = ACQUIRE;
        end
      end
      ACQUIRE: begin
        w_bin_nxt   = w_b_new;
        w_state_nxt = bus.Enable_In ? TRACK : IDLE;
      end
      TRACK: begin
        if (!bus.Enable_In) begin
          w_state_nxt = IDLE;
        end else begin
          w_bin_nxt = w_b_new;
          case (w_delta)
            4'd0: ;
            4'd1: begin
              w_step_nxt = 1'b1;
              w_dir_nxt  = 1'b1;
              w_pos_nxt  = r_pos + POS_WIDTH'(1);
              w_wrap_nxt = (r_bin == 4'd15);
            end
            4'd15: begin
              w_step_nxt = 1'b1;
              w_dir_nxt  = 1'b0;
              w_pos_nxt  = r_pos - POS_WIDTH'(1);
              w_wrap_nxt = (r_bin == 4'd0);
            end
            default: w_err_nxt = 1'b1;
          endcase
        end
      end
      default: w_state_nxt = ACQUIRE;
    endcase
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      r_state <= ACQUIRE;
      r_bin   <= '0;
      r_pos   <= '0;
      r_dir   <= 1'b1;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bin   <= w_bin_nxt;
      r_pos   <= w_pos_nxt;
      r_dir   <= w_dir_nxt;
      r_step  <= w_step_nxt;
      r_wrap  <= w_wrap_nxt;
      r_err   <= w_err_nxt;
    end
  end

`ifdef GRAY_SEQ_ERROR_COUNT_EN
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      r_err_cnt <= '0;
    end else if (w_err_nxt && (r_err_cnt != {ERR_CNT_WIDTH{1'b1}})) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
    end
  end

  assign bus.Error_Count_Out = r_err_cnt;
`else
  assign bus.Error_Count_Out = '0;
`endif

  assign bus.Binary_Out     = r_bin;
  assign bus.Position_Out   = r_pos;
  assign bus.Dir_Out        = r_dir;
  assign bus.Step_Valid_Out = r_step;
  assign bus.Wrap_Out       = r_wrap;
  assign bus.Error_Out      = r_err;

endmodule

`default_nettype wire
